// File: rtl/ctl_game_multi.sv
// Multi-player game controller: per-player BCD score/ammo, IDLE/LOAD/PLAY/GRACE/OVER FSM, winner pick.
// Optional feature: define AMMO_REFILL_EN to make each hit also add one shell.
module ctl_game_multi #(
    parameter int N_PLAYERS    = 2,
    parameter int AMMO_MAX     = 20,
    parameter int WIN_SCORE    = 30,
    parameter int GRACE_FRAMES = 30,
    localparam int WINNER_W    = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   new_frame,
    input  logic                   reset_score,
    input  logic [N_PLAYERS-1:0]   shot_fired,
    input  logic [N_PLAYERS-1:0]   hit,
    output logic [8*N_PLAYERS-1:0] score_bcd,
    output logic [8*N_PLAYERS-1:0] ammo_bcd,
    output logic [N_PLAYERS-1:0]   no_ammo,
    output logic                   playing,
    output logic                   game_over,
    output logic [WINNER_W-1:0]    winner,
    output logic                   tie
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GRACE, S_OVER} state_t;

    localparam logic [7:0] AMMO_BCD  = 8'((AMMO_MAX / 10) * 16 + (AMMO_MAX % 10));
    localparam logic [7:0] WIN_BCD   = 8'((WIN_SCORE / 10) * 16 + (WIN_SCORE % 10));
    localparam logic [7:0] GRACE_END = 8'(GRACE_FRAMES);

    state_t              r_state, w_stateNext;
    logic [7:0]          r_score     [N_PLAYERS];
    logic [7:0]          r_ammo      [N_PLAYERS];
    logic [7:0]          w_scoreNext [N_PLAYERS];
    logic [7:0]          w_ammoNext  [N_PLAYERS];
    logic [7:0]          r_grace, w_graceNext;
    logic [WINNER_W-1:0] r_winner, w_winIdx;
    logic                r_tie, w_tie;
    logic                w_anyWin, w_allDry, w_counting;
    logic [7:0]          w_best;

    function automatic logic [7:0] bcdInc(input logic [7:0] v);
        logic [7:0] res;
        if (v == 8'h99)
            res = v;
        else if (v[3:0] == 4'd9)
            res = {v[7:4] + 4'd1, 4'd0};
        else
            res = {v[7:4], v[3:0] + 4'd1};
        return res;
    endfunction

    function automatic logic [7:0] bcdDec(input logic [7:0] v);
        logic [7:0] res;
        if (v == 8'h00)
            res = v;
        else if (v[3:0] == 4'd0)
            res = {v[7:4] - 4'd1, 4'd9};
        else
            res = {v[7:4], v[3:0] - 4'd1};
        return res;
    endfunction

    // A restart request freezes the counters for the cycle it is seen.
    assign w_counting = ((r_state == S_PLAY) || (r_state == S_GRACE)) && !reset_score;

    always_comb begin
        for (int p = 0; p < N_PLAYERS; p++) begin
            w_scoreNext[p] = r_score[p];
            w_ammoNext[p]  = r_ammo[p];
            if (r_state == S_LOAD) begin
                w_scoreNext[p] = 8'h00;
                w_ammoNext[p]  = AMMO_BCD;
            end else if (w_counting) begin
                if (hit[p])
                    w_scoreNext[p] = bcdInc(r_score[p]);
`ifdef AMMO_REFILL_EN
                if (shot_fired[p] && hit[p]) begin
                    if (r_ammo[p] == 8'h00)
                        w_ammoNext[p] = 8'h01;
                end else if (shot_fired[p]) begin
                    w_ammoNext[p] = bcdDec(r_ammo[p]);
                end else if (hit[p] && (r_ammo[p] < AMMO_BCD)) begin
                    w_ammoNext[p] = bcdInc(r_ammo[p]);
                end
`else
                if (shot_fired[p])
                    w_ammoNext[p] = bcdDec(r_ammo[p]);
`endif
            end
        end
    end

    always_comb begin
        w_anyWin = 1'b0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (r_score[p] >= WIN_BCD)
                w_anyWin = 1'b1;
        end
    end

    assign w_allDry = &no_ammo;

    always_comb begin
        w_stateNext = r_state;
        w_graceNext = r_grace;
        case (r_state)
            S_IDLE: begin
                if (reset_score)
                    w_stateNext = S_LOAD;
            end
            S_LOAD: w_stateNext = S_PLAY;
            S_PLAY: begin
                if (w_anyWin) begin
                    w_stateNext = S_OVER;
                end else if (w_allDry) begin
                    w_stateNext = S_GRACE;
                    w_graceNext = 8'd0;
                end
            end
            S_GRACE: begin
                if (new_frame && (r_grace != GRACE_END))
                    w_graceNext = r_grace + 8'd1;
                if (w_anyWin)
                    w_stateNext = S_OVER;
                else if (r_grace == GRACE_END)
                    w_stateNext = S_OVER;
`ifdef AMMO_REFILL_EN
                else if (!w_allDry)
                    w_stateNext = S_PLAY;
`endif
            end
            S_OVER:  w_stateNext = S_OVER;
            default: w_stateNext = S_IDLE;
        endcase
        if (reset_score && (r_state != S_LOAD))
            w_stateNext = S_LOAD;
    end

    // Winner is judged on the scores that will be frozen, lowest index keeps ties.
    always_comb begin
        w_best   = w_scoreNext[0];
        w_winIdx = '0;
        w_tie    = 1'b0;
        for (int p = 1; p < N_PLAYERS; p++) begin
            if (w_scoreNext[p] > w_best) begin
                w_best   = w_scoreNext[p];
                w_winIdx = WINNER_W'(p);
                w_tie    = 1'b0;
            end else if (w_scoreNext[p] == w_best) begin
                w_tie = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_grace  <= 8'd0;
            r_winner <= '0;
            r_tie    <= 1'b0;
            for (int p = 0; p < N_PLAYERS; p++) begin
                r_score[p] <= 8'h00;
                r_ammo[p]  <= 8'h00;
            end
        end else begin
            r_state <= w_stateNext;
            r_grace <= w_graceNext;
            for (int p = 0; p < N_PLAYERS; p++) begin
                r_score[p] <= w_scoreNext[p];
                r_ammo[p]  <= w_ammoNext[p];
            end
            if (r_state == S_LOAD) begin
                r_winner <= '0;
                r_tie    <= 1'b0;
            end else if ((w_stateNext == S_OVER) && (r_state != S_OVER)) begin
                r_winner <= w_winIdx;
                r_tie    <= w_tie;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < N_PLAYERS; p++) begin
            score_bcd[8*p +: 8] = r_score[p];
            ammo_bcd[8*p +: 8]  = r_ammo[p];
            no_ammo[p]          = (r_ammo[p] == 8'h00);
        end
    end

    assign playing   = (r_state == S_PLAY) || (r_state == S_GRACE);
    assign game_over = (r_state == S_OVER);
    assign winner    = r_winner;
    assign tie       = r_tie;

endmodule

// File: tb/tb_ctl_game_multi.sv
// Scoreboard bench for ctl_game_multi: instance A uses defaults, instance B uses WIN_SCORE=5.
module tb_ctl_game_multi;

    localparam int K_SCORE   = 0;
    localparam int K_AMMO    = 1;
    localparam int K_NOAMMO  = 2;
    localparam int K_PLAYING = 3;
    localparam int K_OVER    = 4;
    localparam int K_WINNER  = 5;
    localparam int K_TIE     = 6;

    typedef struct {
        int          due;
        int          inst;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        newFrameA, resetScoreA, newFrameB, resetScoreB;
    logic [1:0]  shotA, hitA, shotB, hitB;
    logic [15:0] scoreA, ammoA, scoreB, ammoB;
    logic [1:0]  noAmmoA, noAmmoB;
    logic        playingA, overA, tieA, playingB, overB, tieB;
    logic [0:0]  winnerA, winnerB;

    chk_t        sb[$];
    string       nameQ[$];
    int          cycleCnt   = 0;
    int          checkCount = 0;
    int          failCount  = 0;
    logic [31:0] monAct;

    ctl_game_multi dutA (
        .clk        (clock),
        .rst        (reset),
        .new_frame  (newFrameA),
        .reset_score(resetScoreA),
        .shot_fired (shotA),
        .hit        (hitA),
        .score_bcd  (scoreA),
        .ammo_bcd   (ammoA),
        .no_ammo    (noAmmoA),
        .playing    (playingA),
        .game_over  (overA),
        .winner     (winnerA),
        .tie        (tieA)
    );

    ctl_game_multi #(.WIN_SCORE(5)) dutB (
        .clk        (clock),
        .rst        (reset),
        .new_frame  (newFrameB),
        .reset_score(resetScoreB),
        .shot_fired (shotB),
        .hit        (hitB),
        .score_bcd  (scoreB),
        .ammo_bcd   (ammoB),
        .no_ammo    (noAmmoB),
        .playing    (playingB),
        .game_over  (overB),
        .winner     (winnerB),
        .tie        (tieB)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    function automatic logic [31:0] actual(input int inst, input int kind);
        logic [31:0] v;
        v = '0;
        case (kind)
            K_SCORE:   v = (inst == 0) ? {16'b0, scoreA}   : {16'b0, scoreB};
            K_AMMO:    v = (inst == 0) ? {16'b0, ammoA}    : {16'b0, ammoB};
            K_NOAMMO:  v = (inst == 0) ? {30'b0, noAmmoA}  : {30'b0, noAmmoB};
            K_PLAYING: v = (inst == 0) ? {31'b0, playingA} : {31'b0, playingB};
            K_OVER:    v = (inst == 0) ? {31'b0, overA}    : {31'b0, overB};
            K_WINNER:  v = (inst == 0) ? {31'b0, winnerA}  : {31'b0, winnerB};
            K_TIE:     v = (inst == 0) ? {31'b0, tieA}     : {31'b0, tieB};
            default:   v = '1;
        endcase
        return v;
    endfunction

    // Monitor: compare every expectation whose cycle has come, away from the active edge.
    always @(negedge clock) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cycleCnt) begin
                monAct = actual(sb[i].inst, sb[i].kind);
                checkCount++;
                if (monAct !== sb[i].exp) begin
                    failCount++;
                    $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)",
                             nameQ[i], monAct, sb[i].exp, cycleCnt);
                end
                sb.delete(i);
                nameQ.delete(i);
            end
        end
    end

    task automatic checkOutput(input string name, input int inst, input int kind,
                               input logic [31:0] exp, input int delay);
        chk_t c;
        c.due  = cycleCnt + delay;
        c.inst = inst;
        c.kind = kind;
        c.exp  = exp;
        sb.push_back(c);
        nameQ.push_back(name);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input int inst, input logic rs, input logic [1:0] shot,
                                 input logic [1:0] hitV, input logic nf);
        if (inst == 0) begin
            resetScoreA = rs; shotA = shot; hitA = hitV; newFrameA = nf;
        end else begin
            resetScoreB = rs; shotB = shot; hitB = hitV; newFrameB = nf;
        end
        @(posedge clock);
        #1;
        resetScoreA = 1'b0; shotA = 2'b00; hitA = 2'b00; newFrameA = 1'b0;
        resetScoreB = 1'b0; shotB = 2'b00; hitB = 2'b00; newFrameB = 1'b0;
    endtask

    task automatic printSummary();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
        failCount++;
        printSummary();
        $finish;
    end

    initial begin
        reset = 1'b1;
        resetScoreA = 1'b0; shotA = 2'b00; hitA = 2'b00; newFrameA = 1'b0;
        resetScoreB = 1'b0; shotB = 2'b00; hitB = 2'b00; newFrameB = 1'b0;
        idle(2);
        checkOutput("rstScoreA",   0, K_SCORE,   32'h0, 0);
        checkOutput("rstAmmoA",    0, K_AMMO,    32'h0, 0);
        checkOutput("rstNoAmmoA",  0, K_NOAMMO,  32'h3, 0);
        checkOutput("rstPlayingA", 0, K_PLAYING, 32'h0, 0);
        checkOutput("rstOverA",    0, K_OVER,    32'h0, 0);
        checkOutput("rstWinnerA",  0, K_WINNER,  32'h0, 0);
        checkOutput("rstTieA",     0, K_TIE,     32'h0, 0);
        checkOutput("rstNoAmmoB",  1, K_NOAMMO,  32'h3, 0);
        idle(1);
        reset = 1'b0;
        idle(1);

        // Instance B: reaching the win score ends the game, later inputs are ignored.
        checkOutput("loadAmmoB",    1, K_AMMO,    32'h2020, 2);
        checkOutput("loadPlayingB", 1, K_PLAYING, 32'h1,    2);
        applyStimulus(1, 1'b1, 2'b00, 2'b00, 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                checkOutput("winScoreB",   1, K_SCORE,   32'h0005, 1);
                checkOutput("winNotYetB",  1, K_OVER,    32'h0,    1);
                checkOutput("winOverB",    1, K_OVER,    32'h1,    2);
                checkOutput("winPlayingB", 1, K_PLAYING, 32'h0,    2);
                checkOutput("winWinnerB",  1, K_WINNER,  32'h0,    2);
                checkOutput("winTieB",     1, K_TIE,     32'h0,    2);
            end
            applyStimulus(1, 1'b0, 2'b00, 2'b01, 1'b0);
        end
        idle(1);
        checkOutput("overFrozenScoreB", 1, K_SCORE, 32'h0005, 1);
        checkOutput("overFrozenAmmoB",  1, K_AMMO,  32'h2020, 1);
        applyStimulus(1, 1'b0, 2'b11, 2'b11, 1'b0);

        // Instance A: load.
        checkOutput("loadLatencyA", 0, K_PLAYING, 32'h0,    1);
        checkOutput("loadScoreA",   0, K_SCORE,   32'h0,    2);
        checkOutput("loadAmmoA",    0, K_AMMO,    32'h2020, 2);
        checkOutput("loadPlayingA", 0, K_PLAYING, 32'h1,    2);
        checkOutput("loadNoAmmoA",  0, K_NOAMMO,  32'h0,    2);
        applyStimulus(0, 1'b1, 2'b00, 2'b00, 1'b0);
        idle(1);

        for (int i = 0; i < 11; i++) begin
            if (i == 9)  checkOutput("ammoTenA",    0, K_AMMO, 32'h2010, 1);
            if (i == 10) checkOutput("ammoBorrowA", 0, K_AMMO, 32'h2009, 1);
            applyStimulus(0, 1'b0, 2'b01, 2'b00, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 8) checkOutput("scoreNineA", 0, K_SCORE, 32'h0900, 1);
            if (i == 9) begin
                checkOutput("scoreCarryA",   0, K_SCORE, 32'h1000, 1);
                checkOutput("hitKeepsAmmoA", 0, K_AMMO,  32'h2009, 1);
            end
            applyStimulus(0, 1'b0, 2'b00, 2'b10, 1'b0);
        end

        checkOutput("simulAmmoA",  0, K_AMMO,  32'h1908, 1);
        checkOutput("simulScoreA", 0, K_SCORE, 32'h1001, 1);
        applyStimulus(0, 1'b0, 2'b11, 2'b01, 1'b0);

        // Restart mid-play overrides same-cycle events.
        checkOutput("restartFreezeScoreA", 0, K_SCORE,   32'h1001, 1);
        checkOutput("restartFreezeAmmoA",  0, K_AMMO,    32'h1908, 1);
        checkOutput("restartLoadStateA",   0, K_PLAYING, 32'h0,    1);
        checkOutput("restartAmmoA",        0, K_AMMO,    32'h2020, 2);
        checkOutput("restartScoreA",       0, K_SCORE,   32'h0000, 2);
        checkOutput("restartPlayingA",     0, K_PLAYING, 32'h1,    2);
        applyStimulus(0, 1'b1, 2'b11, 2'b11, 1'b0);
        idle(1);

        // Dry-out, late hit in grace, then grace timeout.
        for (int i = 0; i < 3; i++) begin
            if (i == 2) checkOutput("preDryScoreA", 0, K_SCORE, 32'h0303, 1);
            applyStimulus(0, 1'b0, 2'b00, 2'b11, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 19) begin
                checkOutput("dryAmmoA",    0, K_AMMO,    32'h0000, 1);
                checkOutput("dryNoAmmoA",  0, K_NOAMMO,  32'h3,    1);
                checkOutput("dryPlayingA", 0, K_PLAYING, 32'h1,    1);
            end
            applyStimulus(0, 1'b0, 2'b11, 2'b00, 1'b0);
        end
        idle(1);
        checkOutput("gracePlayingA", 0, K_PLAYING, 32'h1,    0);
        checkOutput("lateHitA",      0, K_SCORE,   32'h0403, 1);
        applyStimulus(0, 1'b0, 2'b00, 2'b10, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (i == 29) begin
                checkOutput("graceNotYetA", 0, K_OVER,    32'h0, 1);
                checkOutput("graceOverA",   0, K_OVER,    32'h1, 2);
                checkOutput("overPlayingA", 0, K_PLAYING, 32'h0, 2);
                checkOutput("winnerOneA",   0, K_WINNER,  32'h1, 2);
                checkOutput("noTieA",       0, K_TIE,     32'h0, 2);
            end
            applyStimulus(0, 1'b0, 2'b00, 2'b00, 1'b1);
        end
        idle(1);
        checkOutput("overFrozenScoreA", 0, K_SCORE, 32'h0403, 1);
        checkOutput("overFrozenAmmoA",  0, K_AMMO,  32'h0000, 1);
        applyStimulus(0, 1'b0, 2'b11, 2'b11, 1'b0);

        // Restart from OVER, then equal scores at dry-out.
        checkOutput("reloadLeaveOverA", 0, K_OVER,    32'h0,    1);
        checkOutput("reloadAmmoA",      0, K_AMMO,    32'h2020, 2);
        checkOutput("reloadScoreA",     0, K_SCORE,   32'h0000, 2);
        checkOutput("reloadWinnerA",    0, K_WINNER,  32'h0,    2);
        checkOutput("reloadPlayingA",   0, K_PLAYING, 32'h1,    2);
        applyStimulus(0, 1'b1, 2'b00, 2'b00, 1'b0);
        idle(1);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) checkOutput("tieScoreA", 0, K_SCORE, 32'h0202, 1);
            applyStimulus(0, 1'b0, 2'b00, 2'b11, 1'b0);
        end
        for (int i = 0; i < 20; i++)
            applyStimulus(0, 1'b0, 2'b11, 2'b00, 1'b0);
        idle(1);
        for (int i = 0; i < 30; i++) begin
            if (i == 29) begin
                checkOutput("tieOverA",   0, K_OVER,   32'h1, 2);
                checkOutput("tieWinnerA", 0, K_WINNER, 32'h0, 2);
                checkOutput("tieFlagA",   0, K_TIE,    32'h1, 2);
            end
            applyStimulus(0, 1'b0, 2'b00, 2'b00, 1'b1);
        end
        idle(1);

        // Asynchronous reset mid-play, checked before the next rising edge.
        checkOutput("midPlayingA", 0, K_PLAYING, 32'h1, 2);
        applyStimulus(0, 1'b1, 2'b00, 2'b00, 1'b0);
        idle(1);
        applyStimulus(0, 1'b0, 2'b00, 2'b01, 1'b0);
        applyStimulus(0, 1'b0, 2'b01, 2'b00, 1'b0);
        checkOutput("midScoreA", 0, K_SCORE, 32'h0001, 0);
        checkOutput("midAmmoA",  0, K_AMMO,  32'h2019, 0);
        idle(1);
        reset = 1'b1;
        checkOutput("asyncScoreA",   0, K_SCORE,   32'h0, 0);
        checkOutput("asyncAmmoA",    0, K_AMMO,    32'h0, 0);
        checkOutput("asyncNoAmmoA",  0, K_NOAMMO,  32'h3, 0);
        checkOutput("asyncPlayingA", 0, K_PLAYING, 32'h0, 0);
        checkOutput("asyncOverA",    0, K_OVER,    32'h0, 0);
        @(negedge clock);
        #1;
        reset = 1'b0;
        idle(3);

        if (sb.size() != 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL pending: actual %0d unchecked expectations, required 0", sb.size());
        end
        printSummary();
        $finish;
    end

endmodule
